// File: rtl/ptp_bus_arb.sv
// ptp_bus_arb: two-master arbiter/sequencer for the bus2ip_* slave bus.
// M0 (host CPU) and M1 (PTP sequencer) are served one transaction at a time,
// round robin on a tie. Each transfer becomes a single-cycle rd/wr chip-enable.
// Read data is captured RD_LATENCY cycles after the read strobe. Addresses
// outside the int-ctl, RX-buffer and TX-buffer windows complete at once with
// an error ack and never reach the slave.
`timescale 1ns/1ps
module ptp_bus_arb #(
  parameter int unsigned RD_LATENCY = 2,
  parameter logic [31:0] INT_BADDR  = 32'h0000_0300,
  parameter logic [31:0] RXB_BADDR  = 32'h0000_1000,
  parameter logic [31:0] TXB_BADDR  = 32'h0000_2000
) (
  input  logic        bus2ip_clk,
  input  logic        bus2ip_rst_n,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] bus2ip_addr_o,
  output logic [31:0] bus2ip_data_o,
  output logic        bus2ip_rd_ce_o,
  output logic        bus2ip_wr_ce_o,
  input  logic [31:0] ip2bus_data_i
);

  // The wait counter is 3 bits wide, so latencies 1..7 are representable.
  localparam logic [2:0] RD_LAT = RD_LATENCY[2:0];
  localparam int NWIN = 3;
  localparam int NMST = 2;

  // Window bounds held as 33-bit values so base+size can never wrap.
  localparam logic [NWIN-1:0][32:0] WIN_LO = {
    {1'b0, TXB_BADDR},
    {1'b0, RXB_BADDR},
    {1'b0, INT_BADDR}
  };
  localparam logic [NWIN-1:0][32:0] WIN_HI = {
    {1'b0, TXB_BADDR} + 33'h0_0000_1000,
    {1'b0, RXB_BADDR} + 33'h0_0000_1000,
    {1'b0, INT_BADDR} + 33'h0_0000_0100
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RDWAIT,
    ST_ACK
  } state_t;

  state_t      state_reg, state_next;
  logic        gnt_reg, gnt_next;            // master owning the current transfer
  logic        last_gnt_reg, last_gnt_next;  // round-robin memory
  logic        we_reg, we_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] bus_addr_reg, bus_addr_next;
  logic [31:0] bus_data_reg, bus_data_next;
  logic        rd_ce_reg, rd_ce_next;
  logic        wr_ce_reg, wr_ce_next;

  // Arbitration result for the current IDLE sample.
  logic        any_req;
  logic        sel_gnt;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [NWIN-1:0] win_hit;
  logic        addr_hit;

  // Completion request from the FSM towards the per-master output registers.
  logic        ack_fire;
  logic        ack_err;
  logic        ack_tgt;
  logic        rdata_load;
  logic [31:0] rdata_val;

  logic [NMST-1:0]       ack_vec;
  logic [NMST-1:0]       err_vec;
  logic [NMST-1:0][31:0] rdata_vec;

  assign any_req = m0_req_i | m1_req_i;

  // Pick the requester: a lone request wins, a tie goes to whoever was not served last.
  always_comb begin
    sel_gnt = 1'b0;
    if (m0_req_i && m1_req_i) begin
      sel_gnt = ~last_gnt_reg;
    end else if (m1_req_i) begin
      sel_gnt = 1'b1;
    end
    sel_we    = sel_gnt ? m1_we_i    : m0_we_i;
    sel_addr  = sel_gnt ? m1_addr_i  : m0_addr_i;
    sel_wdata = sel_gnt ? m1_wdata_i : m0_wdata_i;
  end

  // Address decode: one half-open range compare per window.
  genvar gi;
  generate
    for (gi = 0; gi < NWIN; gi++) begin : g_win
      assign win_hit[gi] = ({1'b0, sel_addr} >= WIN_LO[gi]) &&
                           ({1'b0, sel_addr} <  WIN_HI[gi]);
    end
  endgenerate

  assign addr_hit = |win_hit;

  // Next-state and next-output logic; every bus output is the registered copy of a _next value.
  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    last_gnt_next = last_gnt_reg;
    we_next       = we_reg;
    cnt_next      = cnt_reg;
    bus_addr_next = bus_addr_reg;
    bus_data_next = bus_data_reg;
    rd_ce_next    = 1'b0;
    wr_ce_next    = 1'b0;
    ack_fire      = 1'b0;
    ack_err       = 1'b0;
    ack_tgt       = gnt_reg;
    rdata_load    = 1'b0;
    rdata_val     = 32'h0;

    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          gnt_next      = sel_gnt;
          last_gnt_next = sel_gnt;
          we_next       = sel_we;
          if (addr_hit) begin
            state_next    = ST_ISSUE;
            bus_addr_next = sel_addr;
            bus_data_next = sel_wdata;
            wr_ce_next    = sel_we;
            rd_ce_next    = ~sel_we;
          end else begin
            // Decode miss completes without touching the slave; a missed read returns 0.
            state_next = ST_ACK;
            ack_fire   = 1'b1;
            ack_err    = 1'b1;
            ack_tgt    = sel_gnt;
            rdata_load = ~sel_we;
          end
        end
      end

      ST_ISSUE: begin
        if (we_reg) begin
          state_next = ST_ACK;
          ack_fire   = 1'b1;
        end else begin
          state_next = ST_RDWAIT;
          cnt_next   = 3'd1;
        end
      end

      ST_RDWAIT: begin
        if (cnt_reg == RD_LAT) begin
          state_next = ST_ACK;
          ack_fire   = 1'b1;
          rdata_load = 1'b1;
          rdata_val  = ip2bus_data_i;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end

      ST_ACK: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and slave-side registers; reset aborts any transfer in flight.
  always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
    if (!bus2ip_rst_n) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= 1'b0;
      last_gnt_reg <= 1'b1;
      we_reg       <= 1'b0;
      cnt_reg      <= 3'd0;
      bus_addr_reg <= 32'h0;
      bus_data_reg <= 32'h0;
      rd_ce_reg    <= 1'b0;
      wr_ce_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      last_gnt_reg <= last_gnt_next;
      we_reg       <= we_next;
      cnt_reg      <= cnt_next;
      bus_addr_reg <= bus_addr_next;
      bus_data_reg <= bus_data_next;
      rd_ce_reg    <= rd_ce_next;
      wr_ce_reg    <= wr_ce_next;
    end
  end

  // Per-master completion registers; read data is only replaced by a read ack.
  generate
    for (gi = 0; gi < NMST; gi++) begin : g_mst
      logic        ack_reg;
      logic        err_reg;
      logic [31:0] rdata_reg;
      logic        is_tgt;

      assign is_tgt = (ack_tgt == 1'(gi));

      // Pulse ack/err for one cycle and load read data when this master is the target.
      always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= 32'h0;
        end else begin
          ack_reg <= ack_fire & is_tgt;
          err_reg <= ack_fire & ack_err & is_tgt;
          if (rdata_load && is_tgt) begin
            rdata_reg <= rdata_val;
          end
        end
      end

      assign ack_vec[gi]   = ack_reg;
      assign err_vec[gi]   = err_reg;
      assign rdata_vec[gi] = rdata_reg;
    end
  endgenerate

  assign m0_ack_o       = ack_vec[0];
  assign m0_err_o       = err_vec[0];
  assign m0_rdata_o     = rdata_vec[0];
  assign m1_ack_o       = ack_vec[1];
  assign m1_err_o       = err_vec[1];
  assign m1_rdata_o     = rdata_vec[1];
  assign bus2ip_addr_o  = bus_addr_reg;
  assign bus2ip_data_o  = bus_data_reg;
  assign bus2ip_rd_ce_o = rd_ce_reg;
  assign bus2ip_wr_ce_o = wr_ce_reg;

endmodule
